// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: byte/word/state types, S-box, round constants, xtime.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [7:0]        byte_t;
  typedef logic [0:3][7:0]   word_t;
  // state[c][r]: column c, row r; column 0 row 0 is the most significant byte.
  typedef word_t [0:3]       state_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/add_round_key.sv
// XOR of the state with the current round key.
module add_round_key
  import aes_pkg::*;
(
  input  state_t s_in,
  input  state_t rk,
  output state_t s_out
);
  assign s_out = s_in ^ rk;
endmodule

// File: rtl/key_round_step.sv
// One step of the AES-128 key expansion: round key i -> round key i+1.
module key_round_step
  import aes_pkg::*;
(
  input  state_t rk,
  input  byte_t  rcon,
  output state_t nk
);
  word_t sw, w0, w1, w2, w3;

  // SubWord(RotWord(w3)) with the round constant folded into the first byte
  assign sw = {SBOX[rk[3][1]] ^ rcon, SBOX[rk[3][2]], SBOX[rk[3][3]], SBOX[rk[3][0]]};
  assign w0 = rk[0] ^ sw;
  assign w1 = rk[1] ^ w0;
  assign w2 = rk[2] ^ w1;
  assign w3 = rk[3] ^ w2;
  assign nk = {w0, w1, w2, w3};
endmodule

// File: rtl/mix_columns.sv
// Column mix with the fixed matrix {02,03,01,01} in GF(2^8).
module mix_columns
  import aes_pkg::*;
(
  input  state_t s_in,
  output state_t s_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    byte_t a0, a1, a2, a3;
    assign a0 = s_in[c][0];
    assign a1 = s_in[c][1];
    assign a2 = s_in[c][2];
    assign a3 = s_in[c][3];
    assign s_out[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign s_out[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign s_out[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign s_out[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end
endmodule

// File: rtl/shift_rows.sv
// Row r rotates left by r byte positions across the columns.
module shift_rows
  import aes_pkg::*;
(
  input  state_t s_in,
  output state_t s_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign s_out[c][r] = s_in[(c + r) % 4][r];
    end
  end
endmodule

// File: rtl/sub_bytes.sv
// Byte-wise S-box substitution over the whole state.
module sub_bytes
  import aes_pkg::*;
(
  input  state_t s_in,
  output state_t s_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign s_out[c][r] = SBOX[s_in[c][r]];
    end
  end
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath, round keys generated on the fly.
// Optional `AES_ABORT_EN adds an abort input that cancels a block in ROUND or DONE.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
`ifdef AES_ABORT_EN
  input  logic       abort,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     data,
  input  state_t     key,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     o,
  output logic [3:0] round
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] LAST    = 4'(NR);

  logic [1:0] fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  state_t     st_q, st_d, rk_q, rk_d;
  state_t     sb, sr, mc, ark_in, rnd_out, nk;
  byte_t      rcon;
  logic       abort_req;

`ifdef AES_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    rcon = 8'h00;
    if (rnd_q >= 4'd1 && rnd_q <= LAST) rcon = RCON[rnd_q];
  end

  sub_bytes      u_sub (.s_in(st_q),   .s_out(sb));
  shift_rows     u_shr (.s_in(sb),     .s_out(sr));
  mix_columns    u_mix (.s_in(sr),     .s_out(mc));
  // The final round bypasses mix_columns
  assign ark_in = (rnd_q == LAST) ? sr : mc;
  add_round_key  u_ark (.s_in(ark_in), .rk(nk), .s_out(rnd_out));
  key_round_step u_key (.rk(rk_q),     .rcon(rcon), .nk(nk));

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    rk_d  = rk_q;
    rnd_d = rnd_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d  = data ^ key;
          rk_d  = key;
          rnd_d = 4'd1;
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (rnd_q == 4'd0 || rnd_q > LAST) begin
          fsm_d = S_IDLE;
          st_d  = '0;
          rk_d  = '0;
          rnd_d = 4'd0;
        end else begin
          st_d = rnd_out;
          rk_d = nk;
          if (rnd_q == LAST) fsm_d = S_DONE;
          else               rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d = S_IDLE;
          rnd_d = 4'd0;
        end
      end
      default: begin
        fsm_d = S_IDLE;
        st_d  = '0;
        rk_d  = '0;
        rnd_d = 4'd0;
      end
    endcase
    if (abort_req && fsm_q != S_IDLE) begin
      fsm_d = S_IDLE;
      st_d  = '0;
      rk_d  = '0;
      rnd_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      st_q  <= '0;
      rk_q  <= '0;
      rnd_q <= 4'd0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      rk_q  <= rk_d;
      rnd_q <= rnd_d;
    end
  end

  // rst gates in_ready so nothing looks acceptable while reset is held
  assign in_ready  = (fsm_q == S_IDLE) && !rst;
  assign out_valid = (fsm_q == S_DONE);
  assign o         = st_q;
  assign round     = rnd_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer against a table-free AES-128 reference model.
module tb_aes_round_sequencer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] data = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid;
  logic [127:0] o;
  logic [3:0]   round;
`ifdef AES_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sbox_tb [256];

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef AES_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .data(data), .key(key),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .round(round)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the definition: multiplicative inverse then affine map
  task automatic build_sbox;
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] ky);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ky[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tb[tmp[31:24]] ^ rc, sbox_tb[tmp[23:16]], sbox_tb[tmp[15:8]], sbox_tb[tmp[7:0]]};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[4*c]   = gm(t[4*c],8'h02) ^ gm(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1],8'h02) ^ gm(t[4*c+2],8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2],8'h02) ^ gm(t[4*c+3],8'h03);
          s[4*c+3] = gm(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3],8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] k);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin tick; n++; end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    data = pt;
    key = k;
    tick;
    in_valid = 1'b0;
    data = rnd128();
    key = rnd128();
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input int stall, input bit chk_rounds);
    int lat;
    logic [127:0] held;
    out_ready = (stall == 0);
    send(pt, k);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (chk_rounds) check({tag, "_round"}, round, lat + 1);
      tick;
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_o"}, o, exp);
    held = o;
    if (stall > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        check({tag, "_stall_o"}, o, held);
        check({tag, "_stall_round"}, round, 10);
        check({tag, "_stall_vld"}, out_valid, 1);
        check({tag, "_stall_in_ready"}, in_ready, 0);
        tick;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick;
    check({tag, "_post_vld"}, out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
    check({tag, "_post_round"}, round, 0);
  endtask

  initial begin
    logic [127:0] vp [3];
    logic [127:0] vk [3];
    int acc_cyc [3];
    int na, no, cyc, n;
    logic [127:0] p, k;

    build_sbox();
    check("ref_appB", aes_ref(B_PT, B_KEY), B_CT);
    check("ref_appC", aes_ref(C_PT, C_KEY), C_CT);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_round", round, 0);
    check("rst_o", o, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);
    tick;

    run_block("appB", B_PT, B_KEY, B_CT, 0, 1'b1);
    run_block("appC", C_PT, C_KEY, C_CT, 0, 1'b1);
    run_block("bp", B_PT, B_KEY, B_CT, 20, 1'b0);

    for (int i = 0; i < 3; i++) begin vp[i] = rnd128(); vk[i] = rnd128(); end
    na = 0; no = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    data = vp[0];
    key = vk[0];
    while ((na < 3 || no < 3) && cyc < 100) begin
      if (out_valid && no < 3) begin
        check("b2b_o", o, aes_ref(vp[no], vk[no]));
        no++;
      end
      if (in_valid && in_ready && na < 3) begin
        acc_cyc[na] = cyc;
        na++;
      end
      tick;
      cyc++;
      if (na < 3) begin data = vp[na]; key = vk[na]; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_accepted", na, 3);
    check("b2b_outputs", no, 3);
    check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 12);
    check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 12);
    tick;

    send(B_PT, B_KEY);
    n = 0;
    while (round != 4'd5 && n < 20) begin tick; n++; end
    check("mid_round5", round, 5);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_round", round, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    run_block("after_rst", B_PT, B_KEY, B_CT, 0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      p = rnd128();
      k = rnd128();
      run_block("rand", p, k, aes_ref(p, k), int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef AES_ABORT_EN
    begin
      bit seen;
      send(rnd128(), rnd128());
      n = 0;
      while (round != 4'd3 && n < 20) begin tick; n++; end
      check("abort_round3", round, 3);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("abort_round", round, 0);
      check("abort_vld", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      seen = 1'b0;
      repeat (15) begin
        if (out_valid) seen = 1'b1;
        tick;
      end
      check("abort_no_out", seen, 0);
      abort = 1'b1;
      in_valid = 1'b1;
      data = B_PT;
      key = B_KEY;
      tick;
      abort = 1'b0;
      in_valid = 1'b0;
      check("abort_idle_accept", round, 1);
      n = 0;
      while (!out_valid && n < 20) begin tick; n++; end
      check("abort_idle_o", o, B_CT);
      tick;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
